// File: rtl/cmd_pkg.sv
// Shared types and constants for the command dispatcher.
// Holds the opcode map, the FSM state encoding, response bytes, the AFE gain table and the trigger-level clamp.
package cmd_pkg;

  typedef enum logic [7:0] {
    OP_DUMP     = 8'h01,
    OP_GAIN     = 8'h02,
    OP_TRIG_LVL = 8'h03,
    OP_TRIG_POS = 8'h04,
    OP_DEC      = 8'h05,
    OP_TRIG_CFG = 8'h06,
    OP_TRIG_RD  = 8'h07,
    OP_EEP_WR   = 8'h08,
    OP_EEP_RD   = 8'h09,
    OP_GAIN_RD  = 8'h0A
  } opcode_t;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_SPI_WAIT  = 3'd2,
    ST_RESP      = 3'd3,
    ST_WAIT_RESP = 3'd4
  } state_t;

  localparam logic [7:0] ACK_BYTE     = 8'hA5;
  localparam logic [7:0] NACK_BYTE    = 8'hEE;
  localparam logic [7:0] TRIG_LVL_MIN = 8'd46;
  localparam logic [7:0] TRIG_LVL_MAX = 8'd201;
  localparam logic [7:0] SPI_WR_REG   = 8'h13;

  localparam logic [7:0] GAIN_LUT [8] = '{8'h02, 8'h05, 8'h09, 8'h14,
                                          8'h28, 8'h46, 8'h6B, 8'hDD};

  // Keeps the trigger DAC inside the range the front end can actually reach.
  function automatic logic [7:0] sat_lvl(input logic [7:0] ll);
    if (ll < TRIG_LVL_MIN)      return TRIG_LVL_MIN;
    else if (ll > TRIG_LVL_MAX) return TRIG_LVL_MAX;
    else                        return ll;
  endfunction

endpackage

// File: rtl/cmd_wdog.sv
// Stall watchdog for the dispatcher: counts while enabled, restarts on clr,
// and raises expired once the count reaches LIMIT (holding there until cleared).
module cmd_wdog #(
  parameter int LIMIT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt_q, cnt_d;

  assign expired = (cnt_q == 16'(LIMIT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)                cnt_d = '0;
    else if (en && !expired) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Command decoder/dispatcher between the UART command receiver and the scope datapath.
// Optional stall watchdog enabled with `define CMD_DISPATCH_WDOG_EN.
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int SS_W       = 3,
  parameter int TRIG_POS_W = 9,
  parameter int DEC_W      = 4,
  parameter int WDOG_CYC   = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [23:0]           cmd,
  input  logic                  cmd_rdy,
  output logic                  clr_cmd_rdy,
  output logic [7:0]            resp_data,
  output logic                  send_resp,
  input  logic                  resp_sent,
  output logic [15:0]           SPI_data,
  output logic                  wrt_SPI,
  output logic [SS_W-1:0]       ss,
  input  logic                  SPI_done,
  input  logic [7:0]            EEP_data,
  output logic                  dump_en,
  output logic [1:0]            dump_chan,
  output logic [7:0]            trig_cfg,
  output logic [TRIG_POS_W-1:0] trig_pos,
  output logic [DEC_W-1:0]      decimator,
  output logic [3*NUM_CH-1:0]   gain_vec,
  output logic                  busy
);

  // Handshakes: cmd is taken in the IDLE cycle where cmd_rdy is high (clr_cmd_rdy
  // answers in that same cycle); wrt_SPI is a one-cycle request answered by SPI_done
  // any cycle later; send_resp is a one-cycle request answered by resp_sent in the
  // same cycle or any cycle later, with resp_data held stable until then.

  localparam logic [SS_W-1:0] SS_IDLE = '1;
  localparam logic [SS_W-1:0] SS_TRIG = SS_W'(NUM_CH);
  localparam logic [SS_W-1:0] SS_EEP  = SS_W'(NUM_CH + 1);

  state_t                  state_q, state_d;
  logic [23:0]             cmd_q, cmd_d;
  logic [7:0]              resp_q, resp_d;
  logic [15:0]             spi_data_q, spi_data_d;
  logic                    wrt_spi_q, wrt_spi_d;
  logic [SS_W-1:0]         ss_q, ss_d;
  logic                    dump_en_q, dump_en_d;
  logic [1:0]              dump_chan_q, dump_chan_d;
  logic [7:0]              trig_cfg_q, trig_cfg_d;
  logic [TRIG_POS_W-1:0]   trig_pos_q, trig_pos_d;
  logic [DEC_W-1:0]        dec_q, dec_d;
  logic [3*NUM_CH-1:0]     gain_q, gain_d;

  opcode_t    op;
  logic [1:0] cc;
  logic [2:0] ggg;
  logic       cc_ok;
  logic       spi_op;
  logic [2:0] gain_sel;
  logic       wdog_exp;
  logic       unused_cmd_bits;

  assign op     = opcode_t'(cmd_q[23:16]);
  assign cc     = cmd_q[9:8];
  assign ggg    = cmd_q[12:10];
  assign cc_ok  = (int'(cc) < NUM_CH);
  assign spi_op = ((op == OP_GAIN) && cc_ok) || (op == OP_TRIG_LVL) ||
                  (op == OP_EEP_WR) || (op == OP_EEP_RD);
  assign unused_cmd_bits = ^cmd_q[15:14];

  always_comb begin
    gain_sel = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (cc == 2'(i)) gain_sel = gain_q[3*i +: 3];
  end

`ifdef CMD_DISPATCH_WDOG_EN
  logic wdog_clr, wdog_en;
  assign wdog_clr = (state_d != state_q);
  assign wdog_en  = (state_q == ST_SPI_WAIT) || (state_q == ST_WAIT_RESP);

  cmd_wdog #(.LIMIT(WDOG_CYC)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wdog_clr),
    .en      (wdog_en),
    .expired (wdog_exp)
  );
`else
  // Without the watchdog both wait states block indefinitely.
  assign wdog_exp = (WDOG_CYC < 0);
`endif

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (cmd_rdy) state_d = ST_DECODE;
      ST_DECODE:    state_d = spi_op ? ST_SPI_WAIT : ST_RESP;
      ST_SPI_WAIT:  if (SPI_done || wdog_exp) state_d = ST_RESP;
      ST_RESP:      state_d = resp_sent ? ST_IDLE : ST_WAIT_RESP;
      ST_WAIT_RESP: if (resp_sent || wdog_exp) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    clr_cmd_rdy = (state_q == ST_IDLE) && cmd_rdy;
    send_resp   = (state_q == ST_RESP);
    busy        = (state_q != ST_IDLE);
  end

  always_comb begin
    cmd_d       = cmd_q;
    resp_d      = resp_q;
    spi_data_d  = spi_data_q;
    wrt_spi_d   = 1'b0;
    ss_d        = ss_q;
    dump_en_d   = 1'b0;
    dump_chan_d = dump_chan_q;
    trig_cfg_d  = trig_cfg_q;
    trig_pos_d  = trig_pos_q;
    dec_d       = dec_q;
    gain_d      = gain_q;

    if ((state_q == ST_IDLE) && cmd_rdy) cmd_d = cmd;

    unique case (state_q)
      ST_DECODE: begin
        resp_d    = ACK_BYTE;
        wrt_spi_d = spi_op;
        case (op)
          OP_DUMP:
            if (cc_ok) begin
              dump_chan_d = cc;
              dump_en_d   = 1'b1;
            end else begin
              resp_d = NACK_BYTE;
            end
          OP_GAIN:
            if (cc_ok) begin
              spi_data_d = {SPI_WR_REG, GAIN_LUT[ggg]};
              ss_d       = SS_W'(cc);
            end else begin
              resp_d = NACK_BYTE;
            end
          OP_TRIG_LVL: begin
            spi_data_d = {SPI_WR_REG, sat_lvl(cmd_q[7:0])};
            ss_d       = SS_TRIG;
          end
          OP_TRIG_POS: trig_pos_d = cmd_q[TRIG_POS_W-1:0];
          OP_DEC:      dec_d      = cmd_q[DEC_W-1:0];
          OP_TRIG_CFG: trig_cfg_d = {2'b00, cmd_q[13:8]};
          OP_TRIG_RD:  resp_d     = {2'b00, trig_cfg_q[5:0]};
          OP_EEP_WR: begin
            spi_data_d = {2'b01, cmd_q[13:0]};
            ss_d       = SS_EEP;
          end
          OP_EEP_RD: begin
            spi_data_d = {2'b00, cmd_q[13:8], 8'h00};
            ss_d       = SS_EEP;
          end
          OP_GAIN_RD:  resp_d = cc_ok ? {5'b0, gain_sel} : NACK_BYTE;
          default:     resp_d = NACK_BYTE;
        endcase
      end
      ST_SPI_WAIT: begin
        if (SPI_done) begin
          // The gain register only changes once the AFE has actually been written.
          if (op == OP_GAIN)
            for (int i = 0; i < NUM_CH; i++)
              if (cc == 2'(i)) gain_d[3*i +: 3] = ggg;
          if (op == OP_EEP_RD) resp_d = EEP_data;
        end else if (wdog_exp) begin
          ss_d   = SS_IDLE;
          resp_d = NACK_BYTE;
        end
      end
      ST_RESP, ST_WAIT_RESP:
        if (state_d == ST_IDLE) ss_d = SS_IDLE;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q       <= '0;
      resp_q      <= ACK_BYTE;
      spi_data_q  <= '0;
      wrt_spi_q   <= 1'b0;
      ss_q        <= SS_IDLE;
      dump_en_q   <= 1'b0;
      dump_chan_q <= '0;
      trig_cfg_q  <= '0;
      trig_pos_q  <= '0;
      dec_q       <= '0;
      gain_q      <= '0;
    end else begin
      cmd_q       <= cmd_d;
      resp_q      <= resp_d;
      spi_data_q  <= spi_data_d;
      wrt_spi_q   <= wrt_spi_d;
      ss_q        <= ss_d;
      dump_en_q   <= dump_en_d;
      dump_chan_q <= dump_chan_d;
      trig_cfg_q  <= trig_cfg_d;
      trig_pos_q  <= trig_pos_d;
      dec_q       <= dec_d;
      gain_q      <= gain_d;
    end
  end

  assign resp_data = resp_q;
  assign SPI_data  = spi_data_q;
  assign wrt_SPI   = wrt_spi_q;
  assign ss        = ss_q;
  assign dump_en   = dump_en_q;
  assign dump_chan = dump_chan_q;
  assign trig_cfg  = trig_cfg_q;
  assign trig_pos  = trig_pos_q;
  assign decimator = dec_q;
  assign gain_vec  = gain_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Self-checking bench for cmd_dispatch (NUM_CH=3 so out-of-range channels are reachable).
// Responses, SPI words and dumps are scoreboarded; config outputs are checked against a small model.
module tb_cmd_dispatch;

  localparam int NUM_CH     = 3;
  localparam int SS_W       = 3;
  localparam int TRIG_POS_W = 9;
  localparam int DEC_W      = 4;
  localparam int WDOG_CYC   = 100;
  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [23:0]           cmd = '0;
  logic                  cmd_rdy = 1'b0;
  logic                  clr_cmd_rdy;
  logic [7:0]            resp_data;
  logic                  send_resp;
  logic                  resp_sent = 1'b0;
  logic [15:0]           SPI_data;
  logic                  wrt_SPI;
  logic [SS_W-1:0]       ss;
  logic                  SPI_done = 1'b0;
  logic [7:0]            EEP_data = '0;
  logic                  dump_en;
  logic [1:0]            dump_chan;
  logic [7:0]            trig_cfg;
  logic [TRIG_POS_W-1:0] trig_pos;
  logic [DEC_W-1:0]      decimator;
  logic [3*NUM_CH-1:0]   gain_vec;
  logic                  busy;

  // clock / reset
  always #5 clk = ~clk;

  cmd_dispatch #(
    .NUM_CH(NUM_CH), .SS_W(SS_W), .TRIG_POS_W(TRIG_POS_W),
    .DEC_W(DEC_W), .WDOG_CYC(WDOG_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data), .send_resp(send_resp),
    .resp_sent(resp_sent), .SPI_data(SPI_data), .wrt_SPI(wrt_SPI), .ss(ss),
    .SPI_done(SPI_done), .EEP_data(EEP_data), .dump_en(dump_en),
    .dump_chan(dump_chan), .trig_cfg(trig_cfg), .trig_pos(trig_pos),
    .decimator(decimator), .gain_vec(gain_vec), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [18:0] spi_q[$];
  logic [1:0]  dump_q[$];

  logic [7:0] lut [8] = '{8'h02, 8'h05, 8'h09, 8'h14, 8'h28, 8'h46, 8'h6B, 8'hDD};
  logic [2:0] m_gain [4];
  logic [7:0] m_cfg;
  logic [8:0] m_pos;
  logic [3:0] m_dec;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_gain[i] = '0;
    m_cfg = '0;
    m_pos = '0;
    m_dec = '0;
  endtask

  // scoreboard: pop expectations when the DUT produces output
  always @(negedge clk) begin : mon
    logic [18:0] e;
    if (rst_n) begin
      if (send_resp) begin
        if (exp_q.size() == 0) check("resp_unexpected", send_resp, 0);
        else check("resp", resp_data, exp_q.pop_front());
      end
      if (wrt_SPI) begin
        if (spi_q.size() == 0) check("spi_unexpected", wrt_SPI, 0);
        else begin
          e = spi_q.pop_front();
          check("spi_data", SPI_data, e[15:0]);
          check("spi_ss", ss, e[18:16]);
        end
      end
      if (dump_en) begin
        if (dump_q.size() == 0) check("dump_unexpected", dump_en, 0);
        else check("dump_chan", dump_chan, dump_q.pop_front());
      end
    end
  end

  task automatic model_cmd(input logic [23:0] c, input logic [7:0] eep,
                           output logic [7:0] r, output bit spi, output logic [18:0] s);
    logic [1:0] cc;
    logic [7:0] ll;
    logic       ok;
    cc  = c[9:8];
    ll  = c[7:0];
    ok  = (int'(cc) < NUM_CH);
    r   = ACK;
    spi = 1'b0;
    s   = '0;
    case (c[23:16])
      8'h01: if (ok) dump_q.push_back(cc); else r = NACK;
      8'h02: if (ok) begin spi = 1'b1; s = {3'(cc), 8'h13, lut[c[12:10]]}; end
             else r = NACK;
      8'h03: begin
        spi = 1'b1;
        s   = {3'(NUM_CH), 8'h13, (ll < 8'd46) ? 8'd46 : ((ll > 8'd201) ? 8'd201 : ll)};
      end
      8'h04: m_pos = c[8:0];
      8'h05: m_dec = c[3:0];
      8'h06: m_cfg = {2'b00, c[13:8]};
      8'h07: r = {2'b00, m_cfg[5:0]};
      8'h08: begin spi = 1'b1; s = {3'(NUM_CH + 1), 2'b01, c[13:0]}; end
      8'h09: begin spi = 1'b1; s = {3'(NUM_CH + 1), 2'b00, c[13:8], 8'h00}; r = eep; end
      8'h0A: r = ok ? {5'b0, m_gain[cc]} : NACK;
      default: r = NACK;
    endcase
  endtask

  // driver: waits for idle, presents cmd for one capture cycle (called at a negedge)
  task automatic issue(input logic [23:0] c);
    int n;
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    check("idle_timeout", busy, 0);
    cmd     = c;
    cmd_rdy = 1'b1;
    #1 check("clr_cmd_rdy", clr_cmd_rdy, 1);
    @(negedge clk);
    cmd_rdy = 1'b0;
    check("clr_pulse", clr_cmd_rdy, 0);
    check("busy_decode", busy, 1);
  endtask

  task automatic wait_wrt();
    int n;
    n = 0;
    while (!wrt_SPI && n < 20) begin @(negedge clk); n++; end
    check("wrt_timeout", wrt_SPI, 1);
  endtask

  task automatic finish_resp(input bit same);
    int n;
    n = 0;
    while (!send_resp && n < 300) begin @(negedge clk); n++; end
    check("resp_timeout", send_resp, 1);
    if (!same) repeat ($urandom_range(1, 3)) @(negedge clk);
    resp_sent = 1'b1;
    @(negedge clk);
    resp_sent = 1'b0;
    check("busy_after", busy, 0);
    check("ss_idle", ss, 3'b111);
  endtask

  task automatic run_cmd(input logic [23:0] c, input logic [7:0] eep, input bit same);
    logic [7:0]  r;
    bit          spi;
    logic [18:0] s;
    model_cmd(c, eep, r, spi, s);
    if (spi) spi_q.push_back(s);
    exp_q.push_back(r);
    issue(c);
    if (spi) begin
      wait_wrt();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check("ss_hold", ss, s[18:16]);
      SPI_done = 1'b1;
      EEP_data = eep;
      @(negedge clk);
      SPI_done = 1'b0;
      EEP_data = 8'($urandom());
      if (c[23:16] == 8'h02 && int'(c[9:8]) < NUM_CH) m_gain[c[9:8]] = c[12:10];
    end
    finish_resp(same);
    check("trig_cfg", trig_cfg, m_cfg);
    check("trig_pos", trig_pos, m_pos);
    check("decimator", decimator, m_dec);
    check("gain_vec", gain_vec, {m_gain[2], m_gain[1], m_gain[0]});
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got=running exp=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0]  op;
    logic [23:0] c;
    int          n;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check("rst_resp", resp_data, ACK);
    check("rst_ss", ss, 3'b111);
    check("rst_busy", busy, 0);
    check("rst_wrt", wrt_SPI, 0);
    check("rst_trig_cfg", trig_cfg, 0);
    check("rst_gain", gain_vec, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_cmd(24'h060000, 8'h00, 1'b0);
    run_cmd(24'h070000, 8'h00, 1'b0);
    run_cmd(24'h020E01, 8'h00, 1'b1);
    run_cmd(24'h020D01, 8'h00, 1'b0);
    run_cmd(24'h021C00, 8'h00, 1'b0);
    run_cmd(24'h0A0100, 8'h00, 1'b0);
    run_cmd(24'h030010, 8'h00, 1'b0);
    run_cmd(24'h0300F0, 8'h00, 1'b1);
    run_cmd(24'h03002D, 8'h00, 1'b0);
    run_cmd(24'h03002E, 8'h00, 1'b0);
    run_cmd(24'h0300C9, 8'h00, 1'b0);
    run_cmd(24'h0300CA, 8'h00, 1'b0);
    run_cmd(24'h0300A0, 8'h00, 1'b0);
    run_cmd(24'h090500, 8'h5C, 1'b0);
    run_cmd(24'h080312, 8'h00, 1'b1);
    run_cmd(24'h010300, 8'h00, 1'b0);
    run_cmd(24'h1F0000, 8'h00, 1'b0);
    run_cmd(24'h010200, 8'h00, 1'b0);
    run_cmd(24'h020F00, 8'h00, 1'b0);
    run_cmd(24'h0A0300, 8'h00, 1'b0);
    run_cmd(24'h0401AB, 8'h00, 1'b0);
    run_cmd(24'h050007, 8'h00, 1'b1);
    run_cmd(24'h063F00, 8'h00, 1'b0);
    run_cmd(24'h070000, 8'h00, 1'b0);

    for (int i = 0; i < 30; i++) begin
      op = 8'($urandom_range(0, 11));
      c  = {op, 16'($urandom())};
      run_cmd(c, 8'($urandom()), 1'($urandom_range(0, 1)));
    end

    // reset while an SPI transfer is outstanding: no response may follow
    run_cmd(24'h062A00, 8'h00, 1'b0);
    spi_q.push_back({3'(NUM_CH + 1), 2'b01, 14'h0312});
    issue(24'h080312);
    wait_wrt();
    repeat (3) @(negedge clk);
    check("spi_wait_busy", busy, 1);
    rst_n = 1'b0;
    #1 check("mid_rst_ss", ss, 3'b111);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_resp", resp_data, ACK);
    check("mid_rst_cfg", trig_cfg, 0);
    check("mid_rst_gain", gain_vec, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    run_cmd(24'h070000, 8'h00, 1'b0);

`ifdef CMD_DISPATCH_WDOG_EN
    spi_q.push_back({3'(NUM_CH + 1), 2'b01, 14'h0312});
    exp_q.push_back(NACK);
    issue(24'h080312);
    wait_wrt();
    n = 0;
    while (!send_resp && n < 300) begin @(negedge clk); n++; end
    check("wdog_spi_cyc", (n >= 99 && n <= 102), 1);
    check("wdog_ss_idle", ss, 3'b111);
    resp_sent = 1'b1;
    @(negedge clk);
    resp_sent = 1'b0;
    check("wdog_busy", busy, 0);
    exp_q.push_back(ACK);
    m_pos = 9'h011;
    issue(24'h040011);
    n = 0;
    while (busy && n < 300) begin @(negedge clk); n++; end
    check("wdog_resp_cyc", (n >= 99 && n <= 104), 1);
`endif

    check("exp_q_empty", exp_q.size(), 0);
    check("spi_q_empty", spi_q.size(), 0);
    check("dump_q_empty", dump_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
